// File: rtl/lcd1602_responder.sv
// HD44780/LCD1602 bus responder: decodes rs/rw/enable/data, holds DDRAM/CGRAM/AC/flags.
// Latency: transfer executes in the strobe cycle (first enable=0 cycle); effects visible one cycle later.
// Backpressure: busy down-counter on bf_ac[7]; writes while busy are dropped only with LCD_BUSY_CHECK_EN.
module lcd1602_responder #(
  parameter int BUSY_CYCLES  = 40,
  parameter int CLEAR_CYCLES = 1600
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_rs,
  input  logic       i_rw,
  input  logic       i_enable,
  input  logic [7:0] i_data,
  output logic [7:0] o_bf_ac,
  input  logic [6:0] i_ddram_raddr,
  output logic [7:0] o_ddram_rdata,
  input  logic [5:0] i_cgram_raddr,
  output logic [7:0] o_cgram_rdata,
  output logic [6:0] o_ac,
  output logic       o_cgram_sel,
  output logic       o_display_on,
  output logic       o_cursor_on,
  output logic       o_blink_on,
  output logic       o_entry_inc,
  output logic       o_entry_shift,
  output logic       o_two_line,
  output logic       o_bus_8bit,
  output logic [5:0] o_shift_cnt,
  output logic       o_strobe,
  output logic       o_err
);
  localparam int CW = $clog2(CLEAR_CYCLES + 1);

  // Map a DDRAM address to {valid, linear index 0..79} for the current line mode.
  function automatic logic [7:0] f_dd_map(input logic [6:0] a, input logic tl);
    logic [7:0] m;
    m = 8'h00;
    if (tl) begin
      if (a <= 7'h27) m = {1'b1, a};
      else if (a >= 7'h40 && a <= 7'h67) m = {1'b1, a - 7'd24};
    end else if (a <= 7'h4F) begin
      m = {1'b1, a};
    end
    return m;
  endfunction

  // Next address counter value, honouring CGRAM and DDRAM line wrap points.
  function automatic logic [6:0] f_step(input logic [6:0] a, input logic inc,
                                        input logic cg, input logic tl);
    logic [6:0] n;
    n = a;
    if (cg) begin
      n = {1'b0, inc ? a[5:0] + 6'd1 : a[5:0] - 6'd1};
    end else if (tl) begin
      if (inc) n = (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1;
      else     n = (a == 7'h00) ? 7'h67 : (a == 7'h40) ? 7'h27 : a - 7'd1;
    end else begin
      if (inc) n = (a == 7'h4F) ? 7'h00 : a + 7'd1;
      else     n = (a == 7'h00) ? 7'h4F : a - 7'd1;
    end
    return n;
  endfunction

  // Display shift counter steps modulo 40.
  function automatic logic [5:0] f_shift(input logic [5:0] s, input logic inc);
    logic [5:0] n;
    if (inc) n = (s >= 6'd39) ? 6'd0 : s + 6'd1;
    else     n = (s == 6'd0 || s > 6'd39) ? 6'd39 : s - 6'd1;
    return n;
  endfunction

  logic          r_arm, r_pend, r_rs_s, r_rw_s;
  logic [7:0]    r_data_s;
  logic [CW-1:0] r_busy_cnt;
  logic [6:0]    r_ac;
  logic          r_cgram_sel, r_display_on, r_cursor_on, r_blink_on;
  logic          r_entry_inc, r_entry_shift, r_two_line, r_bus_8bit, r_err;
  logic [5:0]    r_shift_cnt;
  logic [7:0]    r_ddram [0:79];
  logic [4:0]    r_cgram [0:63];

  logic       w_busy, w_exec, w_drop, w_do, w_long;
  logic       w_dd_we, w_dd_bad, w_cg_we, w_clear;
  logic [7:0] w_wr_map, w_rd_map;

  assign w_busy = (r_busy_cnt != '0);
  assign w_exec = r_pend && !i_enable && !i_reset;
`ifdef LCD_BUSY_CHECK_EN
  assign w_drop = w_exec && w_busy && !r_rw_s;
`else
  assign w_drop = 1'b0;
`endif
  assign w_do     = w_exec && !r_rw_s && !w_drop;
  assign w_long   = !r_rs_s && (r_data_s[7:2] == 6'd0) && (r_data_s[1:0] != 2'd0);
  assign w_wr_map = f_dd_map(r_ac, r_two_line);
  assign w_rd_map = f_dd_map(i_ddram_raddr, r_two_line);
  assign w_dd_we  = w_do && r_rs_s && !r_cgram_sel && w_wr_map[7];
  assign w_dd_bad = w_do && r_rs_s && !r_cgram_sel && !w_wr_map[7];
  assign w_cg_we  = w_do && r_rs_s && r_cgram_sel;
  assign w_clear  = w_do && !r_rs_s && (r_data_s == 8'h01);

  // Bus sampling, busy counter, address counter and instruction flags.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_arm <= 1'b0;  r_pend <= 1'b0;
      r_rs_s <= 1'b0; r_rw_s <= 1'b0; r_data_s <= 8'h00;
      r_busy_cnt <= '0;
      r_ac <= 7'h00;  r_cgram_sel <= 1'b0;
      r_display_on <= 1'b0; r_cursor_on <= 1'b0; r_blink_on <= 1'b0;
      r_entry_inc <= 1'b0;  r_entry_shift <= 1'b0;
      r_two_line <= 1'b0;   r_bus_8bit <= 1'b1;
      r_shift_cnt <= 6'd0;  r_err <= 1'b0;
    end else begin
      // A pulse already high when reset released is ignored until enable drops.
      r_arm <= r_arm | ~i_enable;
      if (i_enable && r_arm) begin
        r_rs_s <= i_rs; r_rw_s <= i_rw; r_data_s <= i_data; r_pend <= 1'b1;
      end else if (w_exec) begin
        r_pend <= 1'b0;
      end
      if (w_do) r_busy_cnt <= w_long ? CW'(CLEAR_CYCLES) : CW'(BUSY_CYCLES);
      else if (w_busy) r_busy_cnt <= r_busy_cnt - 1'b1;
      if (w_drop || w_dd_bad) r_err <= 1'b1;
      if (w_do && r_rs_s) begin
        r_ac <= f_step(r_ac, r_entry_inc, r_cgram_sel, r_two_line);
        if (r_entry_shift) r_shift_cnt <= f_shift(r_shift_cnt, r_entry_inc);
      end else if (w_do) begin
        casez (r_data_s)
          8'b1???????: begin r_ac <= r_data_s[6:0]; r_cgram_sel <= 1'b0; end
          8'b01??????: begin r_ac <= {1'b0, r_data_s[5:0]}; r_cgram_sel <= 1'b1; end
          8'b001?????: begin r_bus_8bit <= r_data_s[4]; r_two_line <= r_data_s[3]; end
          8'b0001????: begin
            if (r_data_s[3]) r_shift_cnt <= f_shift(r_shift_cnt, r_data_s[2]);
            else r_ac <= f_step(r_ac, r_data_s[2], r_cgram_sel, r_two_line);
          end
          8'b00001???: begin
            r_display_on <= r_data_s[2]; r_cursor_on <= r_data_s[1]; r_blink_on <= r_data_s[0];
          end
          8'b000001??: begin r_entry_inc <= r_data_s[1]; r_entry_shift <= r_data_s[0]; end
          8'b0000001?: begin r_ac <= 7'h00; r_cgram_sel <= 1'b0; r_shift_cnt <= 6'd0; end
          8'b00000001: begin
            r_ac <= 7'h00; r_cgram_sel <= 1'b0; r_entry_inc <= 1'b1; r_shift_cnt <= 6'd0;
          end
          default: ;
        endcase
      end
    end
  end

  // Character RAMs are not reset; clear fills DDRAM with spaces.
  always_ff @(posedge i_clk) begin
    if (w_clear) begin
      for (int i = 0; i < 80; i++) r_ddram[i] <= 8'h20;
    end else if (w_dd_we) begin
      r_ddram[w_wr_map[6:0]] <= r_data_s;
    end
    if (w_cg_we) r_cgram[r_ac[5:0]] <= r_data_s[4:0];
  end

  assign o_bf_ac       = {w_busy, r_ac};
  assign o_ddram_rdata = w_rd_map[7] ? r_ddram[w_rd_map[6:0]] : 8'h00;
  assign o_cgram_rdata = {3'b000, r_cgram[i_cgram_raddr]};
  assign o_ac          = r_ac;
  assign o_cgram_sel   = r_cgram_sel;
  assign o_display_on  = r_display_on;
  assign o_cursor_on   = r_cursor_on;
  assign o_blink_on    = r_blink_on;
  assign o_entry_inc   = r_entry_inc;
  assign o_entry_shift = r_entry_shift;
  assign o_two_line    = r_two_line;
  assign o_bus_8bit    = r_bus_8bit;
  assign o_shift_cnt   = r_shift_cnt;
  assign o_strobe      = w_exec;
  assign o_err         = r_err;
endmodule

// File: doc/lcd1602_responder.md
# lcd1602_responder

Synthesizable model of the HD44780/LCD1602 module side of the parallel bus: it receives `rs`/`rw`/`enable`/`data` from the LCD controller, decodes instructions, maintains DDRAM, CGRAM, address counter and display flags, and exposes them through read ports. It replaces the physical display in simulation and on-board loopback tests of the custom-character controller.

## Interface
- `BUSY_CYCLES`, 40: busy duration in `clk` cycles after any accepted instruction or data write, except clear and home.
- `CLEAR_CYCLES`, 1600: busy duration after clear display (0x01) or return home (0x02/0x03).
- `clk`  in  1  system clock; one clock domain only.
- `reset`  in  1  synchronous, active-high.
- `rs`, `rw`, `enable`  in  1 each  LCD bus controls.
- `data`  in  8  LCD bus data.
- `bf_ac`  out  8  `{busy, ac}`; the status-read value, valid while `rw`=1.
- `ddram_raddr`  in  7  / `ddram_rdata`  out  8  combinational DDRAM read port; invalid address returns 0x00.
- `cgram_raddr`  in  6  / `cgram_rdata`  out  8  combinational CGRAM read port; byte `{3'b0, row}` of char `raddr[5:3]`, row `raddr[2:0]`.
- `ac`  out  7  address counter. `cgram_sel`  out  1  1 = AC points into CGRAM.
- `display_on`, `cursor_on`, `blink_on`, `entry_inc`, `entry_shift`, `two_line`, `bus_8bit`  out  1 each  instruction flags.
- `shift_cnt`  out  6  display shift, 0..39.
- `strobe`  out  1  one-cycle pulse per executed transfer.
- `err`  out  1  sticky protocol/address error flag.

## Operation
- Sampling: `rs`/`rw`/`data` are registered every cycle `enable`=1. The transfer executes on the first cycle `enable`=0 after `enable`=1, using the last sampled values. `strobe` pulses in that cycle.
- A transfer with `rw`=1 has no side effects.
- Instructions (`rs`=0) are decoded by their highest set bit:
  - 0x01 clear: all 80 DDRAM bytes set to 0x20, AC=0, `cgram_sel`=0, `entry_inc`=1, `shift_cnt`=0.
  - 0x02/0x03 return home: AC=0, `cgram_sel`=0, `shift_cnt`=0.
  - 0b000001_IS entry mode: `entry_inc`=I, `entry_shift`=S.
  - 0b00001DCB: sets `display_on`, `cursor_on`, `blink_on`.
  - 0b0001SR__ shift: S=0 steps AC right (R=1) or left (R=0). S=1 steps `shift_cnt` by +1/−1 mod 40.
  - 0b001DNF__ function set: `bus_8bit`=D, `two_line`=N; F is ignored.
  - 0b01aaaaaa: AC=a, `cgram_sel`=1.
  - 0b1aaaaaaa: AC=a, `cgram_sel`=0.
- Data write (`rs`=1): writes `data` to the selected RAM at AC, then AC steps per `entry_inc`. If `entry_shift`=1, `shift_cnt` also steps (+1 for inc, −1 for dec, mod 40).
- CGRAM write stores `data[4:0]`. CGRAM address is `ac[5:0]` and wraps 0x3F↔0x00.
- DDRAM, `two_line`=1: valid ranges 0x00–0x27 (index 0–39) and 0x40–0x67 (index 40–79). Stepping wraps 0x27→0x40, 0x67→0x00, 0x00→0x67 (decrement), 0x40→0x27 (decrement).
- DDRAM, `two_line`=0: valid range 0x00–0x4F, wraps 0x4F↔0x00.
- DDRAM writes at an invalid AC are dropped and set `err`. AC still steps.
- Reset state:
  - All flags 0 except `bus_8bit`=1.
  - AC=0, `cgram_sel`=0, `shift_cnt`=0.
  - `bf_ac`=0x00, `strobe`=0, `err`=0.
  - Busy counter 0.
  - RAM contents are not reset.
- Reset asserted mid-busy or mid-enable-pulse: counter cleared, the pending sample is discarded, and no transfer executes on the following `enable` fall.

## Timing
- Transfer effects, including RAM writes, are visible on the read ports and status outputs one cycle after the `strobe` cycle.
- Busy is a down-counter loaded in the `strobe` cycle. It loads `CLEAR_CYCLES` for clear/home and `BUSY_CYCLES` otherwise; `rw`=1 transfers do not load it. `busy`=1 while the counter is nonzero.
- A new `enable` fall exactly when the counter reaches 0 is accepted.
- `rw`=1 transfers are always accepted, including while busy.

## Configuration
- `LCD_BUSY_CHECK_EN` defined: an `rs`/`rw`=0 transfer while `busy`=1 is dropped (no state change, counter not reloaded), `err` is set, and `strobe` still pulses.
- Undefined: the counter still runs and `bf_ac[7]` still reports busy, but every transfer executes and busy never sets `err`.

## Test plan
- Reset, then instructions 0x38, 0x0C, 0x01 spaced by more than `CLEAR_CYCLES` -> `two_line`=1, `bus_8bit`=1, `display_on`=1, `cursor_on`=0, all DDRAM reads 0x20, AC=0.
- 0x40, then eight data bytes 0x0E,0x11,0x11,0x1F,0x11,0x11,0x11,0x00 -> CGRAM 0..7 hold those values, AC=0x08, `cgram_sel`=1.
- 0xA7 (DDRAM 0x27), data 0x00, data 0x01 -> DDRAM index 39=0x00, index 40 (0x40)=0x01, AC=0x41.
- 0x04 (decrement), 0x80, data 0x41 -> DDRAM 0x00=0x41, AC=0x67. Then 0xE8 (AC=0x68), data write -> `err`=1, DDRAM unchanged.
- With `LCD_BUSY_CHECK_EN`: 0x01 followed by 0x0F 100 cycles later -> `err`=1, `cursor_on`=0. Same sequence without the macro -> `cursor_on`=1, `blink_on`=1, `err`=0.
- Assert `reset` for one cycle while `enable`=1 carrying 0x0F -> no `strobe` on the fall, flags remain at reset values, `bf_ac`=0x00.
